// File: rtl/vx_mem_bus_responder_if.sv
// Request/response bus between a cache-side master and the memory responder.
// master drives requests and rsp_ready; slave drives req_ready and responses.
interface vx_mem_bus_responder_if #(
   parameter int LINE_SIZE  = 64,
   parameter int ADDR_WIDTH = 26,
   parameter int TAG_WIDTH  = 8
);
   logic                   mem_req_valid;
   logic                   mem_req_rw;
   logic [ADDR_WIDTH-1:0]  mem_req_addr;
   logic [8*LINE_SIZE-1:0] mem_req_data;
   logic [LINE_SIZE-1:0]   mem_req_byteen;
   logic [TAG_WIDTH-1:0]   mem_req_tag;
   logic                   mem_req_ready;
   logic                   mem_rsp_valid;
   logic [8*LINE_SIZE-1:0] mem_rsp_data;
   logic [TAG_WIDTH-1:0]   mem_rsp_tag;
   logic                   mem_rsp_ready;

   modport master (
      output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_byteen, mem_req_tag,
      input  mem_req_ready,
      input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
      output mem_rsp_ready
   );

   modport slave (
      input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_byteen, mem_req_tag,
      output mem_req_ready,
      output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
      input  mem_rsp_ready
   );
endinterface

// File: rtl/vx_mem_bus_responder.sv
// Memory-side responder for one mem_bus port: line-wide backing store with
// posted byte-enabled writes and fixed-latency read responses returned in order.
// Read credits (one per response FIFO slot) bound in-flight plus queued reads, so
// the latency pipeline never stalls. Store contents are not reset.
// Optional: define MEM_RSP_PERF_EN to add saturating 44-bit performance counters.
module vx_mem_bus_responder #(
   parameter int LINE_SIZE      = 64,
   parameter int ADDR_WIDTH     = 26,
   parameter int TAG_WIDTH      = 8,
   parameter int NUM_LINES      = 1024,
   parameter int LATENCY        = 4,
   parameter int RSP_QUEUE_SIZE = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   vx_mem_bus_responder_if.slave  bus
`ifdef MEM_RSP_PERF_EN
   ,
   output logic [43:0]            perf_reads,
   output logic [43:0]            perf_writes,
   output logic [43:0]            perf_stalls,
   output logic [43:0]            perf_rsp_stalls
`endif
);
   localparam int DW    = 8 * LINE_SIZE;
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int QW    = $clog2(RSP_QUEUE_SIZE);
   localparam int CW    = QW + 1;
   localparam int NSTG  = LATENCY - 1;

   logic                 rst_done_q;
   logic [CW-1:0]        credits_q;
   logic                 req_fire, rd_fire, wr_fire, rsp_fire;
   logic [IDX_W-1:0]     idx;

   logic [DW-1:0]        store_q [NUM_LINES];

   logic [NSTG-1:0]      stg_vld_q;
   logic [DW-1:0]        stg_data_q [NSTG];
   logic [TAG_WIDTH-1:0] stg_tag_q  [NSTG];

   logic [DW-1:0]        fifo_data_q [RSP_QUEUE_SIZE];
   logic [TAG_WIDTH-1:0] fifo_tag_q  [RSP_QUEUE_SIZE];
   logic [QW:0]          wr_ptr_q, rd_ptr_q;
   logic                 push;

   // Ready depends only on reset state and credits, never on the incoming request.
   assign bus.mem_req_ready = rst_done_q && (credits_q < CW'(RSP_QUEUE_SIZE));
   assign req_fire = bus.mem_req_valid && bus.mem_req_ready;
   assign rd_fire  = req_fire && !bus.mem_req_rw;
   assign wr_fire  = req_fire && bus.mem_req_rw;
   assign rsp_fire = bus.mem_rsp_valid && bus.mem_rsp_ready;
   assign idx      = bus.mem_req_addr[IDX_W-1:0];
   assign push     = stg_vld_q[NSTG-1];

   assign bus.mem_rsp_valid = (wr_ptr_q != rd_ptr_q);
   assign bus.mem_rsp_data  = fifo_data_q[rd_ptr_q[QW-1:0]];
   assign bus.mem_rsp_tag   = fifo_tag_q[rd_ptr_q[QW-1:0]];

   // Hold off requests for the first cycle after reset release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rst_done_q <= 1'b0;
      else       rst_done_q <= 1'b1;
   end

   // Read credits: taken on read accept, returned when a response is consumed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         credits_q <= '0;
      end else begin
         case ({rd_fire, rsp_fire})
            2'b10:   credits_q <= credits_q + CW'(1);
            2'b01:   credits_q <= credits_q - CW'(1);
            default: credits_q <= credits_q;
         endcase
      end
   end

   // Backing store: byte-enabled posted writes; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int b = 0; b < LINE_SIZE; b++) begin
            if (bus.mem_req_byteen[b]) store_q[idx][8*b +: 8] <= bus.mem_req_data[8*b +: 8];
         end
      end
   end

   // Latency pipeline valids; cleared on reset so in-flight reads are dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stg_vld_q <= '0;
      end else begin
         stg_vld_q[0] <= rd_fire;
         for (int s = 1; s < NSTG; s++) stg_vld_q[s] <= stg_vld_q[s-1];
      end
   end

   // Latency pipeline payload: stage 0 is the synchronous store read.
   always_ff @(posedge clk) begin
      if (rd_fire) begin
         stg_data_q[0] <= store_q[idx];
         stg_tag_q[0]  <= bus.mem_req_tag;
      end
      for (int s = 1; s < NSTG; s++) begin
         stg_data_q[s] <= stg_data_q[s-1];
         stg_tag_q[s]  <= stg_tag_q[s-1];
      end
   end

   // Response FIFO pointers; credits guarantee a free slot on every push.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push)     wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rsp_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Response FIFO storage.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_q[wr_ptr_q[QW-1:0]] <= stg_data_q[NSTG-1];
         fifo_tag_q[wr_ptr_q[QW-1:0]]  <= stg_tag_q[NSTG-1];
      end
   end

`ifdef MEM_RSP_PERF_EN
   // Saturating event counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_reads      <= '0;
         perf_writes     <= '0;
         perf_stalls     <= '0;
         perf_rsp_stalls <= '0;
      end else begin
         if (rd_fire && perf_reads != '1)  perf_reads  <= perf_reads + 44'd1;
         if (wr_fire && perf_writes != '1) perf_writes <= perf_writes + 44'd1;
         if (bus.mem_req_valid && !bus.mem_req_ready && perf_stalls != '1)
            perf_stalls <= perf_stalls + 44'd1;
         if (bus.mem_rsp_valid && !bus.mem_rsp_ready && perf_rsp_stalls != '1)
            perf_rsp_stalls <= perf_rsp_stalls + 44'd1;
      end
   end
`endif
endmodule
